// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared parity modes, FSM state encoding and parity helper
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Zero-extended upper bits do not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_if : valid/ready word-input handshake for the UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : single-clock show-ahead FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx : FIFO-buffered UART transmitter, configurable width/parity/stop
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_if.slave                          in_if,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT-1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS-1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS-1);

  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 bit_done;
  logic [DATA_BITS-1:0] head;

  assign in_if.in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push           = in_if.in_valid && in_if.in_ready;
  assign fifo_empty     = (fifo_count == '0);
  assign bit_done       = (baud_q == BAUD_LAST);
  // A pop happens from IDLE, or on the final stop-bit cycle for zero-gap frames.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) ||
                (state_q == ST_STOP && bit_done && bit_q == STOP_LAST));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_if.in_data),
    .dout  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q != ST_IDLE) baud_q <= bit_done ? '0 : baud_q + 1'b1;
      if (pop) begin
        shift_q <= head;
        par_q   <= parity_bit(9'(head), PARITY);
        state_q <= ST_START;
        tx_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: tx_q <= 1'b1;
          ST_START: if (bit_done) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          ST_DATA: if (bit_done) begin
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end
          ST_PARITY: if (bit_done) begin
            state_q <= ST_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
          ST_STOP: if (bit_done) begin
            if (bit_q == STOP_LAST) state_q <= ST_IDLE;
            else                    bit_q   <= bit_q + 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Parametrised UART transmitter with an input FIFO. It takes parallel words over a valid/ready handshake and serialises them onto `tx` as asynchronous frames: start bit, LSB-first data, optional parity, 1 or 2 stop bits. It sits between the SOC's memory-mapped I/O and the board serial pin. It is the synthesisable successor to the fixed 8N1 bit-banger in the CPU bench, adding configurable width, parity, stop bits and buffering.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit, ≥2.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries, power of 2, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a word to send.
- `in_ready`  out  1  FIFO can accept a word this cycle.
- `in_data`  in  DATA_BITS  word to transmit.
- `tx`  out  1  serial line, idles high.
- `busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of words currently buffered.

## Operation
- **Push:** a word is accepted on any rising edge where `in_valid && in_ready`.
  - `in_ready = (fifo_count != FIFO_DEPTH)`, combinational from the count.
  - There is no pass-through when the FIFO is full.
- **Pop:** in IDLE with the FIFO non-empty, the FSM pops the head word on the next edge.
  - The popped word is loaded into the shift register.
  - Parity is computed over the loaded word: odd means the total count of ones in data + parity is odd.
- **FSM states:**
  - IDLE → START when the FIFO is non-empty.
  - START → DATA.
  - DATA → PARITY after DATA_BITS bits; DATA → STOP if PARITY = 0.
  - PARITY → STOP.
  - STOP → START after STOP_BITS bits if the FIFO is non-empty, otherwise → IDLE.
- **Bit timing:** the baud counter runs 0..CLKS_PER_BIT-1. A bit advances when the counter equals CLKS_PER_BIT-1, so every bit is exactly CLKS_PER_BIT cycles.
- **`tx` drive:** `tx` is registered; 0 in START, the shift-register LSB in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
- **Simultaneous push and pop:** the count is unchanged, and both operations complete.
- **Data-in stability:** `in_data` may change freely once accepted. The shifter holds its own copy.

## Timing
- **Reset values** (applied immediately on `rst`, mid-frame included):
  - `tx=1`, `in_ready=1`, `busy=0`, `fifo_count=0`.
  - FSM in IDLE, FIFO flushed; any partial frame is abandoned.
- **Latency:** a word accepted at edge E into an empty FIFO with the FSM in IDLE drives `tx=0` from edge E+1.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Back-to-back frames:** the next start bit begins on the edge immediately after the last stop-bit cycle, with zero idle cycles.
- **Counts:** `fifo_count` reflects a push or pop on the edge after it occurs. `busy` falls on the same edge at which `tx` returns to IDLE.

## Structure
- **Package `uart_pkg`:**
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state encoding `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`.
- **Sub-module `sync_fifo`** (params WIDTH, DEPTH):
  - ports: `clk`, `rst`, `push`, `pop`, `din`, `dout`, `count`;
  - async active-high reset; show-ahead read (`dout` is valid whenever `count` is non-zero).
- **Top-level logic:** the FSM, baud counter, bit counter, shift register and parity register stay in `uart_tx`.

## Test plan
- **8N1 single byte:** defaults, push 0xA5 → `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles; start bit at E+1; `busy` low after 100 cycles.
- **Even / odd parity:** PARITY=2, push 0xA5 → parity bit 0, 110-cycle frame. PARITY=1 → parity bit 1.
- **Burst and backpressure:** hold `in_valid` with 0xA5, 0x35, 0x36, 0x32, 0x0A, 0x55.
  - The first word pops immediately; words 2–5 fill the FIFO and `in_ready` drops.
  - 0x55 is accepted only after the first frame's pop frees a slot.
  - All six frames appear contiguously with no idle gaps.
- **7-bit, 2 stop bits:** DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, push 0x41 → 0,1,0,0,0,0,0,1,1,1; 40-cycle frame.
- **Reset mid-frame:** assert `rst` during the third data bit of 0xA5 with 2 words queued → `tx=1` and `fifo_count=0` immediately; after release no further frame is sent.
- **Simultaneous push and pop:** push a word on the exact edge the FSM pops with `fifo_count=4` → push refused (`in_ready=0`). Repeat with `fifo_count=2` → count stays 2.
